kernel_scheduler: RTL
=====================

Name: kernel_scheduler

Overview:
Shares one iterative `kernel` datapath between NUM_REQ requesters. Each requester submits a 16-bit seed.
- A round-robin arbiter picks one request and latches its seed.
- The block holds kernel `in_valid` high until the kernel raises `out_valid`, then captures the result.
- The result is returned on a single response channel, tagged with the requester ID.
- A watchdog aborts any job whose result does not arrive within TIMEOUT cycles.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, seed/result width; must equal the kernel data width.
- TIMEOUT, 2048, maximum RUN cycles before abort; must exceed 1026.
- IDW, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester job valid.
- req_data  in  NUM_REQ*DATA_W  per-requester seed; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- resp_valid  out  1  response valid.
- resp_data  out  DATA_W  kernel result; 0 when resp_error is 1.
- resp_id  out  IDW  index of the requester that owns the response.
- resp_error  out  1  job aborted by the watchdog.
- resp_ready  in  1  response consumer ready.
- k_in_data  out  DATA_W  seed driven to the kernel.
- k_in_valid  out  1  kernel in_valid.
- k_out_data  in  DATA_W  kernel out_data.
- k_out_valid  in  1  kernel out_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:

Reset:
- On rst=1 at a clock edge, state goes to IDLE.
- resp_valid, resp_error, k_in_valid and busy are 0.
- resp_data, resp_id and k_in_data are 0.
- Round-robin pointer is 0; watchdog counter is 0.
- rst overrides everything, including mid-RUN and mid-RESP: the job is dropped and no response is issued.
- Because k_in_valid falls to 0 on reset, the kernel's own counter restarts.

States: IDLE, RUN, RESP.

IDLE:
- req_ready is combinational: a one-hot grant, asserted only in IDLE.
- The grant goes to the first asserted req_valid at or after the pointer, searching upward with wrap.
- On accept:
  - latch the seed into k_in_data and the index into resp_id;
  - set the pointer to (granted index + 1) mod NUM_REQ;
  - clear the watchdog counter;
  - go to RUN.
- No req_valid: stay in IDLE with req_ready all 0.

RUN:
- k_in_valid = 1 and k_in_data holds the seed; req_ready is all 0.
- The watchdog counter increments each cycle.
- If k_out_valid = 1:
  - capture resp_data <= k_out_data, resp_error <= 0;
  - k_in_valid <= 0;
  - go to RESP.
- Else, if the watchdog reaches TIMEOUT-1:
  - resp_data <= 0, resp_error <= 1;
  - k_in_valid <= 0;
  - go to RESP.
- If both happen in the same cycle, k_out_valid wins and resp_error is 0.

Kernel latency:
- With k_in_valid first sampled high at edge 0, the kernel drives k_out_valid visible after edge 1025.
- The nominal job is therefore 1026 RUN cycles.

RESP:
- resp_valid = 1; resp_data, resp_id and resp_error are held stable.
- k_in_valid = 0. RESP lasts at least one cycle, which guarantees the single low in_valid cycle the kernel needs to clear its counter.
- On resp_valid & resp_ready: clear resp_valid and go to IDLE.
- The next grant can occur in that IDLE cycle, so back-to-back jobs take 1026 + 2 cycles minimum with resp_ready tied high.

Other rules:
- k_out_valid is ignored outside RUN.
- A requester that drops req_valid before it is granted is simply skipped.
- req_data is sampled only at accept.
- busy = (state != IDLE).

Test Plan:
1. Single job, seed handling:
   - Stimulus: rst for 2 cycles, then req_valid[2]=1 with seed 7 and resp_ready=1.
   - Response: req_ready[2] pulses for 1 cycle; k_in_valid is high for exactly 1026 cycles; resp_valid, resp_data=7 (since 7>>3=0), resp_id=2, resp_error=0.
2. Round-robin fairness:
   - Stimulus: all four req_valid held high with seeds 0, 1, 7, 0.
   - Response: grants occur in order 0, 1, 2, 3, 0; responses return data 0, 1, 7, 0 with matching IDs.
3. Backpressure:
   - Stimulus: resp_ready=0 for 50 cycles after resp_valid rises.
   - Response: resp_valid, resp_data and resp_id hold stable; k_in_valid=0 throughout; no new grant until the handshake; the next job's result is correct (kernel counter has cleared).
4. Timeout:
   - Stimulus: kernel replaced by a stub that never asserts k_out_valid; one request from requester 1.
   - Response: after exactly TIMEOUT=2048 RUN cycles, resp_valid=1, resp_error=1, resp_data=0, resp_id=1.
5. Reset mid-RUN:
   - Stimulus: assert rst 500 cycles into a job.
   - Response: next cycle has state IDLE, k_in_valid=0, no response issued, pointer=0; a subsequent request from requester 3 with seed 1 completes with resp_data=1.
6. Stray k_out_valid:
   - Stimulus: pulse k_out_valid while in IDLE and while in RESP.
   - Response: no state change and no data corruption.

Source files
------------

// File: rtl/kernel_scheduler.sv
// Round-robin share of one iterative kernel among NUM_REQ requesters; one job in flight, watchdog abort.
// Job cost is kernel latency + 2 cycles (grant, response); resp_ready low holds RESP and blocks all grants.
module kernel_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 2048,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic [IDW-1:0]            resp_id,
    output logic                      resp_error,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         k_in_data,
    output logic                      k_in_valid,
    input  logic [DATA_W-1:0]         k_out_data,
    input  logic                      k_out_valid,
    output logic                      busy
);

    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [WDW-1:0]      wdog_q, wdog_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rerr_q, rerr_d;

    logic [NUM_REQ-1:0]  grant_oh;
    logic [IDW-1:0]      gidx;
    logic                found;
    logic [IDW:0]        idx_w;
    logic [IDW-1:0]      idx;

    // First asserted request at or after the pointer, searching upward with wrap.
    always_comb begin
        grant_oh = '0;
        gidx     = '0;
        found    = 1'b0;
        idx_w    = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx_w >= (IDW+1)'(NUM_REQ)) begin
                idx_w = idx_w - (IDW+1)'(NUM_REQ);
            end
            idx = idx_w[IDW-1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found) begin
            grant_oh[gidx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        seed_d  = seed_q;
        id_d    = id_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    seed_d  = req_data[int'(gidx)*DATA_W +: DATA_W];
                    id_d    = gidx;
                    ptr_d   = (gidx == IDW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
                    wdog_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                wdog_d = wdog_q + 1'b1;
                // A result arriving on the last watchdog cycle still counts as success.
                if (k_out_valid) begin
                    rdata_d = k_out_data;
                    rerr_d  = 1'b0;
                    state_d = RESP;
                end else if (wdog_q == WDW'(TIMEOUT-1)) begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wdog_q  <= '0;
            seed_q  <= '0;
            id_q    <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
            seed_q  <= seed_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    // in_valid tracks RUN exactly, so every RESP cycle gives the kernel its counter-clearing low.
    assign req_ready  = (state_q == IDLE) ? grant_oh : '0;
    assign resp_valid = (state_q == RESP);
    assign k_in_valid = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign k_in_data  = seed_q;
    assign resp_id    = id_q;
    assign resp_data  = rdata_q;
    assign resp_error = rerr_q;

endmodule
